// File: rtl/bias_add_4_pkg.sv
// +----------------------------------------------------------------------+
// | bias_add_4_pkg : layer-4 sizes and FSM encoding for bias_add_4       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package bias_add_4_pkg;

  localparam int c_acc_width_4   = 32;
  localparam int c_coeff_width   = 16;
  localparam int c_kern_s_k_4    = 16;
  localparam int c_npix_4        = 64;
  localparam int c_out_shift_4   = 8;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bias_add_4_if.sv
// +----------------------------------------------------------------------+
// | bias_add_4_if : accumulator, bias and output ap_fifo signal bundle   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface bias_add_4_if
  import bias_add_4_pkg::*;
#(
  parameter int ACC_WIDTH   = c_acc_width_4,
  parameter int COEFF_WIDTH = c_coeff_width,
  parameter int OUT_WIDTH   = c_coeff_width
);

  logic signed [ACC_WIDTH-1:0]   input_V_dout;
  logic                          input_V_empty_n;
  logic                          input_V_read;
  logic signed [COEFF_WIDTH-1:0] bias_V_dout;
  logic                          bias_V_empty_n;
  logic                          bias_V_read;
  logic signed [OUT_WIDTH-1:0]   output_V_din;
  logic                          output_V_full_n;
  logic                          output_V_write;

  modport slave (
    input  input_V_dout,
    input  input_V_empty_n,
    output input_V_read,
    input  bias_V_dout,
    input  bias_V_empty_n,
    output bias_V_read,
    output output_V_din,
    input  output_V_full_n,
    output output_V_write
  );

  modport master (
    output input_V_dout,
    output input_V_empty_n,
    input  input_V_read,
    output bias_V_dout,
    output bias_V_empty_n,
    input  bias_V_read,
    input  output_V_din,
    output output_V_full_n,
    input  output_V_write
  );

endinterface

`default_nettype wire

// File: rtl/bias_add_sat.sv
// +----------------------------------------------------------------------+
// | bias_add_sat : signed bias add, arithmetic shift, ReLU, saturation   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bias_add_sat
  import bias_add_4_pkg::*;
#(
  parameter int ACC_WIDTH   = c_acc_width_4,
  parameter int COEFF_WIDTH = c_coeff_width,
  parameter int OUT_WIDTH   = c_coeff_width,
  parameter int OUT_SHIFT   = c_out_shift_4,
  parameter int RELU        = 0
) (
  input  wire logic signed [ACC_WIDTH-1:0]   i_acc,
  input  wire logic signed [COEFF_WIDTH-1:0] i_bias,
  output logic signed [OUT_WIDTH-1:0]        o_result
);

  localparam int SW = ACC_WIDTH + 1;

  logic signed [SW-1:0]           w_acc_x;
  logic signed [SW-1:0]           w_bias_x;
  logic signed [SW-1:0]           w_sum;
  logic signed [SW-1:0]           w_shift;
  logic signed [SW-1:0]           w_clip;
  logic        [SW-OUT_WIDTH:0]   w_hi;
  logic                           w_fits;

  assign w_acc_x  = {{(SW-ACC_WIDTH){i_acc[ACC_WIDTH-1]}}, i_acc};
  assign w_bias_x = {{(SW-COEFF_WIDTH){i_bias[COEFF_WIDTH-1]}}, i_bias};
  assign w_sum    = w_acc_x + w_bias_x;
  assign w_shift  = w_sum >>> OUT_SHIFT;

  generate
    if (RELU != 0) begin : g_relu
      assign w_clip = w_shift[SW-1] ? '0 : w_shift;
    end else begin : g_no_relu
      assign w_clip = w_shift;
    end
  endgenerate

  // Representable iff every bit above the output sign bit copies it.
  assign w_hi   = w_clip[SW-1:OUT_WIDTH-1];
  assign w_fits = (&w_hi) | ~(|w_hi);

  always_comb begin
    o_result = w_clip[OUT_WIDTH-1:0];
    if (!w_fits) begin
      o_result = w_clip[SW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                              : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/bias_add_4.sv
// +----------------------------------------------------------------------+
// | bias_add_4 : per-channel bias cache and add stage for layer 4        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bias_add_4
  import bias_add_4_pkg::*;
#(
  parameter int ACC_WIDTH   = c_acc_width_4,
  parameter int COEFF_WIDTH = c_coeff_width,
  parameter int OUT_WIDTH   = c_coeff_width,
  parameter int NUM_CH      = c_kern_s_k_4,
  parameter int NUM_PIX     = c_npix_4,
  parameter int OUT_SHIFT   = c_out_shift_4,
  parameter int RELU        = 0
) (
  input wire logic     ap_clk,
  input wire logic     ap_rst,
  bias_add_4_if.slave  bus
);

  localparam int CH_W  = idx_width(NUM_CH);
  localparam int PIX_W = idx_width(NUM_PIX);

  localparam logic [CH_W-1:0]  c_ch_last  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]  c_ch_one   = CH_W'(1);
  localparam logic [PIX_W-1:0] c_pix_last = PIX_W'(NUM_PIX - 1);
  localparam logic [PIX_W-1:0] c_pix_one  = PIX_W'(1);

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [CH_W-1:0]               r_load_idx;
  logic [CH_W-1:0]               r_ch_idx;
  logic [PIX_W-1:0]              r_pix_cnt;
  logic                          r_out_valid;
  logic signed [OUT_WIDTH-1:0]   r_out_reg;
  logic signed [COEFF_WIDTH-1:0] r_bias_mem [NUM_CH];
  logic signed [OUT_WIDTH-1:0]   w_result;
  logic                          w_bias_rd;
  logic                          w_in_rd;
  logic                          w_out_wr;

  // Strobes are gated by reset since the reset state itself would pop biases.
  always_comb begin
    w_state_nxt = r_state;
    w_bias_rd   = 1'b0;
    w_in_rd     = 1'b0;
    w_out_wr    = r_out_valid & bus.output_V_full_n;
    case (r_state)
      ST_LOAD: begin
        w_bias_rd = bus.bias_V_empty_n & ~ap_rst;
        if (w_bias_rd && (r_load_idx == c_ch_last)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_in_rd = bus.input_V_empty_n & (~r_out_valid | bus.output_V_full_n) & ~ap_rst;
        if (w_in_rd && (r_ch_idx == c_ch_last) && (r_pix_cnt == c_pix_last)) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_load_idx  <= '0;
      r_ch_idx    <= '0;
      r_pix_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_reg   <= '0;
    end else begin
      if (w_bias_rd) begin
        r_load_idx <= (r_load_idx == c_ch_last) ? '0 : r_load_idx + c_ch_one;
      end
      if (w_in_rd) begin
        r_ch_idx <= (r_ch_idx == c_ch_last) ? '0 : r_ch_idx + c_ch_one;
        if (r_ch_idx == c_ch_last) begin
          r_pix_cnt <= (r_pix_cnt == c_pix_last) ? '0 : r_pix_cnt + c_pix_one;
        end
      end
      if (w_in_rd) begin
        r_out_valid <= 1'b1;
        r_out_reg   <= w_result;
      end else if (w_out_wr) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_bias_rd) begin
      r_bias_mem[r_load_idx] <= bus.bias_V_dout;
    end
  end

  bias_add_sat #(
    .ACC_WIDTH   (ACC_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .OUT_SHIFT   (OUT_SHIFT),
    .RELU        (RELU)
  ) u_sat (
    .i_acc    (bus.input_V_dout),
    .i_bias   (r_bias_mem[r_ch_idx]),
    .o_result (w_result)
  );

  assign bus.bias_V_read    = w_bias_rd;
  assign bus.input_V_read   = w_in_rd;
  assign bus.output_V_write = w_out_wr;
  assign bus.output_V_din   = r_out_reg;

endmodule

`default_nettype wire

// File: tb/tb_bias_add_4.sv
// +----------------------------------------------------------------------+
// | tb_bias_add_4 : vector table and FIFO scoreboard bench for bias_add_4|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bias_add_4;

  localparam int NCH   = 4;
  localparam int NPIX  = 2;
  localparam int FRAME = NCH * NPIX;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bias_add_4_if #(.ACC_WIDTH(32), .COEFF_WIDTH(16), .OUT_WIDTH(16)) u_if ();

  bias_add_4 #(
    .ACC_WIDTH(32), .COEFF_WIDTH(16), .OUT_WIDTH(16),
    .NUM_CH(NCH), .NUM_PIX(NPIX), .OUT_SHIFT(0), .RELU(0)
  ) u_dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (u_if)
  );

  logic signed [31:0] t_acc;
  logic signed [15:0] t_bias;
  logic signed [15:0] t_res8;
  logic signed [15:0] t_resr;

  bias_add_sat #(.ACC_WIDTH(32), .COEFF_WIDTH(16), .OUT_WIDTH(16), .OUT_SHIFT(8), .RELU(0))
    u_sat8 (.i_acc(t_acc), .i_bias(t_bias), .o_result(t_res8));
  bias_add_sat #(.ACC_WIDTH(32), .COEFF_WIDTH(16), .OUT_WIDTH(16), .OUT_SHIFT(8), .RELU(1))
    u_satr (.i_acc(t_acc), .i_bias(t_bias), .o_result(t_resr));

  typedef struct {
    int acc;
    int bias;
    int e8;
    int er;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int bq[$];
  int aq[$];
  int expq[$];
  int cyc = 0;
  int b_pops = 0;
  int i_pops = 0;
  int n_wr = 0;
  bit s_in_rd, s_b_rd, s_wr;
  logic signed [31:0] s_din;

  function automatic int model(input int acc, input int bias, input int sh, input bit relu);
    longint s;
    s = longint'(acc) + longint'(bias);
    s = s >>> sh;
    if (relu && s < 0) s = 0;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: cycle budget expired (t=%0t)", name, $time);
  endtask

  // One clock: drive FIFO sides at the negedge, sample strobes just before the posedge.
  task automatic cycle(input bit b_en, input bit a_en, input bit f_en);
    u_if.bias_V_empty_n  = b_en && (bq.size() > 0);
    u_if.bias_V_dout     = (bq.size() > 0) ? 16'(bq[0]) : 16'sd0;
    u_if.input_V_empty_n = a_en && (aq.size() > 0);
    u_if.input_V_dout    = (aq.size() > 0) ? aq[0] : 0;
    u_if.output_V_full_n = f_en;
    #4;
    s_b_rd  = u_if.bias_V_read;
    s_in_rd = u_if.input_V_read;
    s_wr    = u_if.output_V_write;
    s_din   = u_if.output_V_din;
    if (s_b_rd) begin
      check("bias_pop_order", i_pops, FRAME * (b_pops / NCH));
      check("bias_pop_nonempty", u_if.bias_V_empty_n, 1);
      if (bq.size() > 0) void'(bq.pop_front());
      b_pops++;
    end
    if (s_in_rd) begin
      check("acc_pop_order", b_pops, NCH * (i_pops / FRAME + 1));
      check("acc_pop_nonempty", u_if.input_V_empty_n, 1);
      if (aq.size() > 0) void'(aq.pop_front());
      i_pops++;
    end
    if (s_wr) begin
      if (expq.size() == 0) check("unexpected_write", s_din, 32'sh7fff_ffff);
      else check("out_data", s_din, expq.pop_front());
      n_wr++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_frame();
    int b[NCH];
    for (int c = 0; c < NCH; c++) begin
      b[c] = int'($signed(16'($urandom)));
      bq.push_back(b[c]);
    end
    for (int i = 0; i < FRAME; i++) begin
      int a;
      a = int'($urandom) >>> $urandom_range(0, 31);
      aq.push_back(a);
      expq.push_back(model(a, b[i % NCH], 0, 1'b0));
    end
  endtask

  task automatic drain(input bit rnd, input int max_cyc, input string name);
    int k;
    k = 0;
    while ((expq.size() > 0 || aq.size() > 0 || bq.size() > 0) && k < max_cyc) begin
      if (rnd) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      else cycle(1'b1, 1'b1, 1'b1);
      k++;
    end
    if (k >= max_cyc) timeout(name);
  endtask

  task automatic run_writes(input int n, input string name);
    int base, k;
    base = n_wr;
    k = 0;
    while (n_wr - base < n && k < 100) begin
      cycle(1'b1, 1'b1, 1'b1);
      k++;
    end
    if (k >= 100) timeout(name);
  endtask

  initial begin
    vec_t tbl[14];
    int   basic_exp[FRAME];
    bit   prev_rd;
    int   first_wr, last_wr, last_bpop, c0, base_wr;
    logic signed [31:0] held;

    // Combinational unit vectors for the arithmetic stage.
    tbl[0]  = '{32'h7FFFFFFF, 0, 32767, 32767};
    tbl[1]  = '{32'h80000000, 0, -32768, 0};
    tbl[2]  = '{-1, 0, -1, 0};
    tbl[3]  = '{-300, 0, -2, 0};
    tbl[4]  = '{32'h7FFFFFFF, 32767, 32767, 32767};
    tbl[5]  = '{32'h80000000, -32768, -32768, 0};
    tbl[6]  = '{25855, 1, 101, 101};
    tbl[7]  = '{8388352, 255, 32767, 32767};
    tbl[8]  = '{8388608, 0, 32767, 32767};
    tbl[9]  = '{-8388608, 0, -32768, 0};
    tbl[10] = '{-8388609, 0, -32768, 0};
    tbl[11] = '{1000, -1000, 0, 0};
    tbl[12] = '{-256, -1, -2, 0};
    tbl[13] = '{255, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      t_acc  = tbl[i].acc;
      t_bias = 16'(tbl[i].bias);
      #1;
      check("sat_shift8_vec", t_res8, tbl[i].e8);
      check("sat_relu_vec", t_resr, tbl[i].er);
    end
    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = int'($urandom) >>> $urandom_range(0, 31);
      b = int'($signed(16'($urandom)));
      t_acc  = a;
      t_bias = 16'(b);
      #1;
      check("sat_shift8_rand", t_res8, model(a, b, 8, 1'b0));
      check("sat_relu_rand", t_resr, model(a, b, 8, 1'b1));
    end

    // Reset state with both sources offering data.
    u_if.bias_V_empty_n  = 1'b1;
    u_if.bias_V_dout     = 16'sd5;
    u_if.input_V_empty_n = 1'b1;
    u_if.input_V_dout    = 32'sd7;
    u_if.output_V_full_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_write", u_if.output_V_write, 0);
    check("rst_din", u_if.output_V_din, 0);
    check("rst_bias_read", u_if.bias_V_read, 0);
    check("rst_input_read", u_if.input_V_read, 0);
    rst = 1'b0;
    cycle(1'b1, 1'b1, 1'b1);

    // Basic frame with hand-derived results.
    bq = '{1, -2, 3, -4};
    aq = '{10, 11, 12, 13, 14, 15, 16, 17};
    basic_exp = '{11, 9, 15, 9, 15, 13, 19, 13};
    foreach (basic_exp[i]) expq.push_back(basic_exp[i]);
    prev_rd = 1'b0;
    first_wr = -1; last_wr = -1; last_bpop = -1;
    base_wr = n_wr;
    for (int i = 0; i < 14; i++) begin
      c0 = cyc;
      cycle(1'b1, 1'b1, 1'b1);
      check("latency_1cyc", s_wr, prev_rd);
      prev_rd = s_in_rd;
      if (s_b_rd) last_bpop = c0;
      if (s_wr) begin
        if (first_wr < 0) first_wr = c0;
        last_wr = c0;
      end
    end
    check("basic_writes", n_wr - base_wr, FRAME);
    check("basic_consecutive", last_wr - first_wr, FRAME - 1);
    check("basic_first_write", first_wr, last_bpop + 2);
    check("basic_drained", expq.size(), 0);

    // Backpressure for five cycles mid-frame.
    push_frame();
    run_writes(3, "bp_prefill");
    held = expq.size() > 0 ? expq[0] : 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      check("bp_no_write", s_wr, 0);
      check("bp_no_pop", s_in_rd, 0);
      check("bp_held_data", s_din, held);
    end
    drain(1'b0, 100, "bp_drain");
    check("bp_drained", expq.size(), 0);

    // Two frames with the second bias set already queued.
    base_wr = n_wr;
    push_frame();
    push_frame();
    drain(1'b0, 200, "multi_drain");
    check("multi_writes", n_wr - base_wr, 2 * FRAME);

    // Random starvation and backpressure across several frames.
    base_wr = n_wr;
    for (int f = 0; f < 4; f++) push_frame();
    drain(1'b1, 3000, "starve_drain");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
    check("starve_writes", n_wr - base_wr, 4 * FRAME);

    // Asynchronous reset after three outputs of a frame.
    push_frame();
    run_writes(3, "rst_prefill");
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_write", u_if.output_V_write, 0);
    check("mid_rst_din", u_if.output_V_din, 0);
    check("mid_rst_bias_read", u_if.bias_V_read, 0);
    check("mid_rst_input_read", u_if.input_V_read, 0);
    bq.delete();
    aq.delete();
    expq.delete();
    b_pops = 0;
    i_pops = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    base_wr = n_wr;
    push_frame();
    drain(1'b0, 100, "post_rst_drain");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
    check("post_rst_writes", n_wr - base_wr, FRAME);
    check("post_rst_bias_pops", b_pops, NCH);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
